// File: rtl/mram_request_arbiter.sv
// ---------------------------------------------------------------------------
// mram_request_arbiter
//
// Two-requester round-robin arbiter that issues one command per MRAM
// transaction frame to the MRAM control sequencer. A free-running frame
// counter splits time into frames of FRAME_LEN cycles. Arbitration and the
// FSM decision happen on the last cycle of a frame and take effect on the
// following cycle 0, so the command on read_write_sel is stable for a whole
// frame. A frame after a READ frame carries the read data out of the part,
// so a write cannot follow a read directly: a DRAIN frame is inserted.
//
// Parameters
//   FRAME_LEN    cycles per frame (frame counter runs 0..FRAME_LEN-1), >= 2
//   RD_DONE_CYC  cycle of the frame following a READ frame at which the read
//                data has been shifted out, 1..FRAME_LEN-1
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   req[1:0]        request level per requester
//   req_rw[1:0]     operation per requester (1 = write, 0 = read)
//   req_bytes[3:0]  byte select per requester, [2i+1:2i] for requester i
//   read_write_sel  command {bytes[1:0], rw}; 3'b000 = idle/drain
//   frame_start     one-cycle pulse on frame cycle 0
//   gnt[1:0]        one-hot pulse on cycle 0 of the frame a command starts
//   done[1:0]       one-hot pulse when a granted transaction completes
//   busy            high during WRITE, READ and DRAIN frames
// ---------------------------------------------------------------------------
module mram_request_arbiter #(
    parameter int FRAME_LEN   = 23,
    parameter int RD_DONE_CYC = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] req_rw,
    input  logic [3:0] req_bytes,
    output logic [2:0] read_write_sel,
    output logic       frame_start,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    // done is registered, so it is launched one cycle ahead of the cycle it
    // must be visible on.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_WR_DONE = CNT_W'(FRAME_LEN - 2);
    localparam logic [CNT_W-1:0] CNT_RD_DONE = CNT_W'(RD_DONE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             running;     // set on the first edge after reset release
    logic [CNT_W-1:0] cnt;
    logic             frame_end;

    logic             ptr;         // round-robin priority position
    logic             cur_id;      // requester owning the current frame's command
    logic             rd_done_id;  // requester of the read issued last frame
    logic             rd_pend;     // last frame was a READ frame

    logic             win_vld;
    logic             win_id;
    logic             win_rw;
    logic [1:0]       win_bytes;
    logic             issue;

    logic [2:0]       sel_nxt;
    logic [1:0]       gnt_nxt;
    logic [1:0]       done_nxt;

    assign frame_end = running && (cnt == CNT_LAST);

    // -----------------------------------------------------------------------
    // Round-robin pick: requester at the pointer wins if it asks, otherwise
    // the other one.
    // -----------------------------------------------------------------------
    always_comb begin
        win_vld   = |req;
        win_id    = req[ptr] ? ptr : ~ptr;
        win_rw    = req_rw[win_id];
        win_bytes = win_id ? req_bytes[3:2] : req_bytes[1:0];
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state; decided only on the last cycle of a frame
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (frame_end) begin
            case (state)
                ST_READ: begin
                    // Only another read may follow a read; anything else
                    // waits one DRAIN frame while the read data goes out.
                    if (win_vld && !win_rw) begin
                        state_nxt = ST_READ;
                        issue     = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
                default: begin
                    if (!win_vld) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = win_rw ? ST_WRITE : ST_READ;
                        issue     = 1'b1;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM outputs: next values of the registered command/grant/done, plus
    // the combinational status outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_nxt  = read_write_sel;
        gnt_nxt  = 2'b00;
        done_nxt = 2'b00;

        if (frame_end) begin
            sel_nxt = issue ? {win_bytes, win_rw} : 3'b000;
            if (issue) begin
                gnt_nxt[win_id] = 1'b1;
            end
        end

        // A write completes at the end of its own frame; a read completes
        // inside the following frame. Those two frames are never the same
        // frame (the one after a READ is READ or DRAIN), so done stays
        // one-hot.
        if (running && (state == ST_WRITE) && (cnt == CNT_WR_DONE)) begin
            done_nxt[cur_id] = 1'b1;
        end
        if (running && rd_pend && (cnt == CNT_RD_DONE)) begin
            done_nxt[rd_done_id] = 1'b1;
        end

        busy        = (state != ST_IDLE);
        frame_start = running && (cnt == '0);
    end

    // -----------------------------------------------------------------------
    // Frame counter, arbitration bookkeeping and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running        <= 1'b0;
            cnt            <= '0;
            ptr            <= 1'b0;
            cur_id         <= 1'b0;
            rd_done_id     <= 1'b0;
            rd_pend        <= 1'b0;
            read_write_sel <= 3'b000;
            gnt            <= 2'b00;
            done           <= 2'b00;
        end else begin
            // The counter holds at 0 across the first edge so that edge
            // opens frame cycle 0.
            running <= 1'b1;
            if (running) begin
                cnt <= frame_end ? '0 : cnt + CNT_W'(1);
            end

            if (frame_end) begin
                // Remember who read in the ending frame before cur_id is
                // overwritten by a pipelined read.
                rd_pend    <= (state == ST_READ);
                rd_done_id <= cur_id;
                if (issue) begin
                    cur_id <= win_id;
                    ptr    <= ~win_id;
                end
            end

            read_write_sel <= sel_nxt;
            gnt            <= gnt_nxt;
            done           <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mram_request_arbiter.sv
module tb_mram_request_arbiter;

    localparam int FL   = 23;
    localparam int RD   = 17;
    localparam int MAXF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] req_rw = 2'b00;
    logic [3:0] req_bytes = 4'b0000;
    logic [2:0] read_write_sel;
    logic       frame_start;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Per-frame stimulus (applied on cycle 0 of the frame) and per-frame
    // expected outputs.
    logic [1:0] s_req   [MAXF];
    logic [1:0] s_rw    [MAXF];
    logic [3:0] s_bytes [MAXF];
    logic [2:0] e_sel   [MAXF];
    logic [1:0] e_gnt   [MAXF];
    logic [1:0] e_done  [MAXF];
    int         e_dcyc  [MAXF];
    logic       e_busy  [MAXF];

    // Scoreboard of expected {sel, gnt, done, busy, frame_start} per cycle.
    logic [8:0] sb_q[$];

    mram_request_arbiter #(
        .FRAME_LEN   (FL),
        .RD_DONE_CYC (RD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_rw         (req_rw),
        .req_bytes      (req_bytes),
        .read_write_sel (read_write_sel),
        .frame_start    (frame_start),
        .gnt            (gnt),
        .done           (done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {read_write_sel, gnt, done, busy, frame_start};
    endfunction

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {sel,gnt,done,busy,fs} got %b required %b", tag, got, exp);
        end
    endtask

    task automatic clear_frames();
        for (int f = 0; f < MAXF; f++) begin
            s_req[f] = 2'b00; s_rw[f] = 2'b00; s_bytes[f] = 4'b0000;
            e_sel[f] = 3'b000; e_gnt[f] = 2'b00; e_done[f] = 2'b00;
            e_dcyc[f] = -1; e_busy[f] = 1'b0;
        end
    endtask

    task automatic frm(input int f, input logic [1:0] rq, input logic [1:0] rw,
                       input logic [3:0] by, input logic [2:0] sel,
                       input logic [1:0] g, input logic [1:0] d, input int dc,
                       input logic b);
        s_req[f] = rq; s_rw[f] = rw; s_bytes[f] = by;
        e_sel[f] = sel; e_gnt[f] = g; e_done[f] = d; e_dcyc[f] = dc; e_busy[f] = b;
    endtask

    task automatic apply_stim(input int f);
        req       = s_req[f];
        req_rw    = s_rw[f];
        req_bytes = s_bytes[f];
    endtask

    task automatic push_frame(input int f);
        logic [1:0] g;
        logic [1:0] d;
        logic       fs;
        for (int c = 0; c < FL; c++) begin
            g  = (c == 0) ? e_gnt[f] : 2'b00;
            d  = (c == e_dcyc[f]) ? e_done[f] : 2'b00;
            fs = (c == 0);
            sb_q.push_back({e_sel[f], g, d, e_busy[f], fs});
        end
    endtask

    // Reset, release, then run nfr frames comparing every cycle. If abort_f
    // is non-negative, reset is reasserted mid-cycle at (abort_f, abort_c).
    task automatic run_scen(input string name, input int nfr,
                            input int abort_f, input int abort_c);
        logic [8:0] exp;
        rst = 1'b1;
        apply_stim(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, " in_reset"}, outs(), 9'b0);
        rst = 1'b0;
        sb_q.delete();
        for (int f = 0; f < nfr; f++) begin
            for (int c = 0; c < FL; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    apply_stim(f);
                    push_frame(f);
                end
                if (sb_q.size() == 0) begin
                    chk($sformatf("%s sb_empty f%0d c%0d", name, f, c), outs(), 9'bx);
                end else begin
                    exp = sb_q.pop_front();
                    chk($sformatf("%s f%0d c%0d", name, f, c), outs(), exp);
                end
                if (f == abort_f && c == abort_c) begin
                    rst = 1'b1;
                    #1;
                    chk({name, " abort_reset"}, outs(), 9'b0);
                    sb_q.delete();
                    return;
                end
            end
        end
    endtask

    initial begin
        // Single write from requester0, full bytes.
        clear_frames();
        frm(0, 2'b01, 2'b01, 4'b0011, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b00, 2'b00, 4'b0000, 3'b111, 2'b01, 2'b01, 22, 1'b1);
        frm(2, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("wr_single", 3, -1, 0);

        // Requester1 read, lower byte, then drain.
        clear_frames();
        frm(0, 2'b10, 2'b00, 4'b0100, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b00, 2'b00, 4'b0000, 3'b010, 2'b10, 2'b00, -1, 1'b1);
        frm(2, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b10, 17, 1'b1);
        frm(3, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("rd_drain", 4, -1, 0);

        // Both requesters write continuously: grants alternate.
        clear_frames();
        for (int f = 0; f < 5; f++) frm(f, 2'b11, 2'b11, 4'b1001, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b11, 2'b11, 4'b1001, 3'b011, 2'b01, 2'b01, 22, 1'b1);
        frm(2, 2'b11, 2'b11, 4'b1001, 3'b101, 2'b10, 2'b10, 22, 1'b1);
        frm(3, 2'b11, 2'b11, 4'b1001, 3'b011, 2'b01, 2'b01, 22, 1'b1);
        frm(4, 2'b11, 2'b11, 4'b1001, 3'b101, 2'b10, 2'b10, 22, 1'b1);
        run_scen("wr_contend", 5, -1, 0);

        // Requester0 read, requester1 write: READ, DRAIN, WRITE.
        clear_frames();
        frm(0, 2'b11, 2'b10, 4'b0111, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b10, 2'b10, 4'b0111, 3'b110, 2'b01, 2'b00, -1, 1'b1);
        frm(2, 2'b10, 2'b10, 4'b0111, 3'b000, 2'b00, 2'b01, 17, 1'b1);
        frm(3, 2'b00, 2'b00, 4'b0000, 3'b011, 2'b10, 2'b10, 22, 1'b1);
        frm(4, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("rd_then_wr", 5, -1, 0);

        // Back-to-back reads: READ, READ, DRAIN.
        clear_frames();
        frm(0, 2'b11, 2'b00, 4'b1110, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b10, 2'b00, 4'b1110, 3'b100, 2'b01, 2'b00, -1, 1'b1);
        frm(2, 2'b00, 2'b00, 4'b0000, 3'b110, 2'b10, 2'b01, 17, 1'b1);
        frm(3, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b10, 17, 1'b1);
        frm(4, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("rd_rd", 5, -1, 0);

        // Nop read (bytes 00) is still granted and completed.
        clear_frames();
        frm(0, 2'b01, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b01, 2'b00, -1, 1'b1);
        frm(2, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b01, 17, 1'b1);
        frm(3, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("nop_rd", 4, -1, 0);

        // Write followed directly by a read: WRITE, READ, DRAIN.
        clear_frames();
        frm(0, 2'b11, 2'b01, 4'b1111, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b10, 2'b01, 4'b1111, 3'b111, 2'b01, 2'b01, 22, 1'b1);
        frm(2, 2'b00, 2'b00, 4'b0000, 3'b110, 2'b10, 2'b00, -1, 1'b1);
        frm(3, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b10, 17, 1'b1);
        frm(4, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("wr_then_rd", 5, -1, 0);

        // Reset at cycle 10 of a READ frame granted to requester0.
        clear_frames();
        frm(0, 2'b01, 2'b00, 4'b0011, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b00, 2'b00, 4'b0000, 3'b110, 2'b01, 2'b00, -1, 1'b1);
        run_scen("rst_mid_rd", 2, 1, 10);

        // After that reset the pointer is back at requester0 and the aborted
        // read produces no done.
        clear_frames();
        frm(0, 2'b11, 2'b11, 4'b1111, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        frm(1, 2'b10, 2'b11, 4'b1111, 3'b111, 2'b01, 2'b01, 22, 1'b1);
        frm(2, 2'b00, 2'b00, 4'b0000, 3'b111, 2'b10, 2'b10, 22, 1'b1);
        frm(3, 2'b00, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00, -1, 1'b0);
        run_scen("post_rst", 4, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
